// File: rtl/dsp_col_frame_strobe_gen.sv
// Column frame-strobe generator: filters frame-address commands by column and emits a guarded one-hot strobe.
// Optional feature macro: STROBE_COUNT_EN adds the 16-bit strobe_count register (tied to zero otherwise).
module dsp_col_frame_strobe_gen #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int ColID            = 0,
  parameter int SetupCycles      = 2,
  parameter int StrobeCycles     = 1
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [FrameSelectWidth-1:0] col_sel,
  input  logic [4:0]                  frame_idx,
  input  logic                        err_clr,
  output logic [MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                        busy,
  output logic                        err_range,
  output logic [15:0]                 strobe_count
);

  localparam int CntMax = (SetupCycles > StrobeCycles) ? SetupCycles : StrobeCycles;
  localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [4:0]                 idx_q, idx_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       err_q, err_d;
  logic [MaxFramesPerCol-1:0] idx_onehot;
  logic                       accept;
  logic                       hit;
  logic                       in_range;

  for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_dec
    assign idx_onehot[gi] = (idx_q == 5'(gi));
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign hit       = (col_sel == FrameSelectWidth'(ColID)) || (&col_sel);
  assign in_range  = ({27'd0, frame_idx} < 32'(MaxFramesPerCol));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    strobe_d = strobe_q;
    err_d    = err_q;
    // Clear first so that a fresh range error in the same cycle overrides it.
    if (err_clr) begin
      err_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept && hit) begin
          if (in_range) begin
            state_d = SETUP;
            idx_d   = frame_idx;
            cnt_d   = CntW'(SetupCycles - 1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d  = STROBE;
          cnt_d    = CntW'(StrobeCycles - 1);
          strobe_d = idx_onehot;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d  = HOLD;
          strobe_d = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      HOLD: begin
        state_d  = IDLE;
        strobe_d = '0;
      end
      default: begin
        state_d  = IDLE;
        strobe_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign FrameStrobe = strobe_q;
  assign err_range   = err_q;

`ifdef STROBE_COUNT_EN
  logic [15:0] count_q, count_d;

  // Counts STROBE entries; wraps naturally at 16 bits.
  always_comb begin
    count_d = count_q;
    if (state_q == SETUP && cnt_q == '0) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign strobe_count = count_q;
`else
  assign strobe_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dsp_col_frame_strobe_gen.sv
// Self-checking bench: timing-window reference model for random traffic, vector table for StrobeCycles=3.
module tb_dsp_col_frame_strobe_gen;

  localparam int S = 2;
  localparam int W = 1;

  logic        CLK = 1'b0;
  logic        reset;
  logic        cmd_valid, err_clr;
  logic [4:0]  col_sel, frame_idx;
  logic        cmd_ready, busy, err_range;
  logic [19:0] FrameStrobe;
  logic [15:0] strobe_count;

  logic        v3, ec3;
  logic [4:0]  cs3, fi3;
  logic        rdy3, busy3, err3;
  logic [19:0] fs3;
  logic [15:0] cnt3;

  int checks = 0;
  int failures = 0;

  int         edge_n = 0;
  int         acc = -1000;
  logic [4:0] m_idx = 5'd0;
  bit         m_err = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  always #5 CLK = ~CLK;

  dsp_col_frame_strobe_gen u_dut (
    .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .col_sel(col_sel), .frame_idx(frame_idx), .err_clr(err_clr),
    .FrameStrobe(FrameStrobe), .busy(busy), .err_range(err_range),
    .strobe_count(strobe_count)
  );

  dsp_col_frame_strobe_gen #(.StrobeCycles(3)) u_dut3 (
    .CLK(CLK), .reset(reset), .cmd_valid(v3), .cmd_ready(rdy3),
    .col_sel(cs3), .frame_idx(fi3), .err_clr(ec3),
    .FrameStrobe(fs3), .busy(busy3), .err_range(err3),
    .strobe_count(cnt3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  function automatic logic [15:0] exp_count();
`ifdef STROBE_COUNT_EN
    return m_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  // Drive one command at the negedge, advance one edge, compare at the next negedge.
  task automatic step(input logic v, input logic [4:0] cs, input logic [4:0] fi, input logic ec);
    int e;
    bit rdy, hit, in_win_busy, in_win_strobe;
    logic [19:0] exp_fs;
    cmd_valid = v; col_sel = cs; frame_idx = fi; err_clr = ec;
    e   = edge_n + 1;
    rdy = (e > acc + S + W + 1);
    check("cmd_ready", 32'(cmd_ready), 32'(rdy));
    hit = (cs == 5'd0) || (cs == 5'h1F);
    if (ec) m_err = 1'b0;
    if (v && rdy && hit) begin
      if (fi < 5'd20) begin
        acc   = e;
        m_idx = fi;
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge CLK);
    edge_n = e;
    if (e == acc + S) m_cnt = m_cnt + 16'd1;
    @(negedge CLK);
    in_win_busy   = (e >= acc) && (e <= acc + S + W);
    in_win_strobe = (e >= acc + S) && (e <= acc + S + W - 1);
    exp_fs = in_win_strobe ? (20'(1) << m_idx) : 20'h0;
    check("FrameStrobe", 32'(FrameStrobe), 32'(exp_fs));
    check("busy", 32'(busy), 32'(in_win_busy));
    check("err_range", 32'(err_range), 32'(m_err));
    check("strobe_count", 32'(strobe_count), 32'(exp_count()));
    cmd_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic model_reset();
    acc = -1000; m_err = 1'b0; m_cnt = 16'd0;
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  idx;
    logic [19:0] exp_fs;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [14];

  initial begin
    // Hold cmd_valid through the whole first transfer; second accept only once back in IDLE.
    vecs[0]  = '{1'b1, 5'd1, 20'h0, 1'b1};
    vecs[1]  = '{1'b1, 5'd2, 20'h0, 1'b1};
    vecs[2]  = '{1'b1, 5'd2, 20'h2, 1'b1};
    vecs[3]  = '{1'b1, 5'd2, 20'h2, 1'b1};
    vecs[4]  = '{1'b1, 5'd2, 20'h2, 1'b1};
    vecs[5]  = '{1'b1, 5'd2, 20'h0, 1'b1};
    vecs[6]  = '{1'b1, 5'd2, 20'h0, 1'b0};
    vecs[7]  = '{1'b1, 5'd2, 20'h0, 1'b1};
    vecs[8]  = '{1'b1, 5'd2, 20'h0, 1'b1};
    vecs[9]  = '{1'b1, 5'd2, 20'h4, 1'b1};
    vecs[10] = '{1'b1, 5'd2, 20'h4, 1'b1};
    vecs[11] = '{1'b1, 5'd2, 20'h4, 1'b1};
    vecs[12] = '{1'b0, 5'd2, 20'h0, 1'b1};
    vecs[13] = '{1'b0, 5'd2, 20'h0, 1'b0};

    reset = 1'b1;
    cmd_valid = 1'b0; col_sel = 5'd0; frame_idx = 5'd0; err_clr = 1'b0;
    v3 = 1'b0; cs3 = 5'd0; fi3 = 5'd0; ec3 = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_FrameStrobe", 32'(FrameStrobe), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err_range), 32'h0);
    check("rst_count", 32'(strobe_count), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h1);
    reset = 1'b0;

    // Basic transfer: accept at T, strobe after T+2, low after T+3, ready after T+4.
    step(1'b1, 5'd0, 5'd3, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    check("T2_strobe_const", 32'(FrameStrobe), 32'h00008);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    check("T3_strobe_const", 32'(FrameStrobe), 32'h0);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    check("T4_ready_const", 32'(cmd_ready), 32'h1);

    // Broadcast to top frame.
    for (int i = 0; i < 6; i++) step(i == 0, 5'h1F, 5'd19, 1'b0);
    // Miss: accepted, dropped.
    for (int i = 0; i < 3; i++) step(i == 0, 5'd7, 5'd0, 1'b0);
    // Range error, held, then cleared, then set+clr together.
    for (int i = 0; i < 3; i++) step(i == 0, 5'd0, 5'd20, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b1);
    step(1'b1, 5'd0, 5'd31, 1'b1);
    check("err_set_wins_const", 32'(err_range), 32'h1);
    step(1'b0, 5'd0, 5'd0, 1'b1);

    // StrobeCycles=3 instance: held cmd_valid, back-to-back strobes never overlap.
    for (int i = 0; i < 14; i++) begin
      v3 = vecs[i].v; fi3 = vecs[i].idx;
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("sc3_fs[%0d]", i), 32'(fs3), 32'(vecs[i].exp_fs));
      check($sformatf("sc3_busy[%0d]", i), 32'(busy3), 32'(vecs[i].exp_busy));
    end
    v3 = 1'b0;

    // Random traffic against the window model.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] cs;
      case ($urandom_range(0, 3))
        0: cs = 5'd0;
        1: cs = 5'h1F;
        default: cs = 5'($urandom_range(0, 31));
      endcase
      step(($urandom_range(0, 2) != 0), cs, 5'($urandom_range(0, 23)),
           ($urandom_range(0, 7) == 0));
    end

    // Reset asserted mid-STROBE with idx=5.
    for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 5'd0, 1'b1);
    step(1'b1, 5'd0, 5'd5, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    check("pre_rst_strobe", 32'(FrameStrobe), 32'h00020);
    reset = 1'b1;
    #1;
    check("midrst_strobe", 32'(FrameStrobe), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_ready", 32'(cmd_ready), 32'h1);
    check("midrst_count", 32'(strobe_count), 32'h0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
